nios2_oci_dct_packer: RTL and testbench

NIOS2_OCI_DCT_PACKER -- requirements
Module: nios2_oci_dct_packer

---
 rtl/nios2_oci_dct_pkg.sv | 17 +
 rtl/nios2_oci_dct_packer.sv | 108 ++++++++++
 tb/tb_nios2_oci_dct_packer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/nios2_oci_dct_pkg.sv
// Shared definitions for the data-capture trace packer: slot geometry,
// output widths and the packer state encoding.
package nios2_oci_dct_pkg;

  localparam int unsigned DCT_SLOT_W = 2;
  localparam int unsigned DCT_SLOTS  = 15;
  localparam int unsigned DCT_BUF_W  = 30;
  localparam int unsigned DCT_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_HOLD,
    ST_DRAIN,
    ST_ENDED
  } dct_state_e;

endpackage

// File: rtl/nios2_oci_dct_packer.sv
// Packs SLOT_W-bit data-capture trace items into a 30-bit buffer and hands
// full or flushed buffers downstream; end_req drains the last buffer and stops.
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
#(
  parameter int unsigned SLOT_W = DCT_SLOT_W,
  parameter int unsigned SLOTS  = DCT_SLOTS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [SLOT_W-1:0]        in_bits,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     end_req,
  output logic [SLOT_W*SLOTS-1:0]  dct_buffer,
  output logic [DCT_CNT_W-1:0]     dct_count,
  output logic                     pkt_valid,
  output logic [SLOT_W*SLOTS-1:0]  pkt_data,
  output logic [DCT_CNT_W-1:0]     pkt_count,
  input  logic                     pkt_ready,
  output logic                     test_ending,
  output logic                     test_has_ended
);

  localparam int unsigned BW = SLOT_W * SLOTS;
  localparam logic [DCT_CNT_W-1:0] LAST_SLOT = DCT_CNT_W'(SLOTS - 1);

  dct_state_e            r_state, w_state_nxt;
  logic [BW-1:0]         r_buf, w_buf_nxt;
  logic [DCT_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic                  r_end_lat, w_end_lat_nxt;
  logic                  r_test_ending, r_test_has_ended;
  logic                  w_accept;
  logic                  w_has_items;

  assign in_ready    = (r_state == ST_FILL);
  assign pkt_valid   = (r_state == ST_HOLD) || (r_state == ST_DRAIN);
  assign w_accept    = in_valid && in_ready;
  // Buffer is non-empty once this cycle's item (if any) has been packed.
  assign w_has_items = w_accept || (r_cnt != '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_buf_nxt     = r_buf;
    w_cnt_nxt     = r_cnt;
    w_end_lat_nxt = r_end_lat;
    if (w_accept) begin
      w_buf_nxt = {r_buf[BW-SLOT_W-1:0], in_bits};
      w_cnt_nxt = r_cnt + DCT_CNT_W'(1);
    end
    case (r_state)
      ST_FILL: begin
        if (end_req)
          w_state_nxt = w_has_items ? ST_DRAIN : ST_ENDED;
        else if (w_accept && (r_cnt == LAST_SLOT))
          w_state_nxt = ST_HOLD;
        else if (flush && w_has_items)
          w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (end_req)
          w_end_lat_nxt = 1'b1;
        if (pkt_ready) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = (r_end_lat || end_req) ? ST_ENDED : ST_FILL;
        end
      end
      ST_DRAIN: begin
        if (pkt_ready) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ENDED;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_FILL;
      r_buf            <= '0;
      r_cnt            <= '0;
      r_end_lat        <= 1'b0;
      r_test_ending    <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_buf            <= w_buf_nxt;
      r_cnt            <= w_cnt_nxt;
      r_end_lat        <= w_end_lat_nxt;
      // Ending covers both the drain and a HOLD that already saw end_req.
      r_test_ending    <= (w_state_nxt == ST_DRAIN) ||
                          ((w_state_nxt == ST_HOLD) && w_end_lat_nxt);
      r_test_has_ended <= (w_state_nxt == ST_ENDED);
    end
  end

  assign dct_buffer     = r_buf;
  assign dct_count      = r_cnt;
  assign pkt_data       = r_buf;
  assign pkt_count      = r_cnt;
  assign test_ending    = r_test_ending;
  assign test_has_ended = r_test_has_ended;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Self-checking bench for nios2_oci_dct_packer: a queue-based model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [1:0]  in_bits;
  logic        in_ready;
  logic        flush;
  logic        end_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        pkt_valid;
  logic [29:0] pkt_data;
  logic [3:0]  pkt_count;
  logic        pkt_ready;
  logic        test_ending;
  logic        test_has_ended;

  int n_tests = 0;
  int n_fail  = 0;

  nios2_oci_dct_packer #(.SLOT_W(2), .SLOTS(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_bits(in_bits), .in_ready(in_ready),
    .flush(flush), .end_req(end_req),
    .dct_buffer(dct_buffer), .dct_count(dct_count),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_count(pkt_count),
    .pkt_ready(pkt_ready),
    .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: items held in the buffer, whether they are sealed as a packet,
  // whether an end has been requested, and whether the run has ended.
  logic [1:0] m_items[$];
  bit m_sealed, m_end_pend, m_ended;

  function automatic logic [29:0] m_pack();
    logic [29:0] b = '0;
    foreach (m_items[i]) b = {b[27:0], m_items[i]};
    return b;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_items.delete();
      m_sealed = 0; m_end_pend = 0; m_ended = 0;
    end else if (!m_ended) begin
      if (!m_sealed) begin
        if (in_valid) m_items.push_back(in_bits);
        if (end_req) begin
          if (m_items.size() > 0) begin m_sealed = 1; m_end_pend = 1; end
          else m_ended = 1;
        end else if (m_items.size() == 15 || (flush && m_items.size() > 0)) begin
          m_sealed = 1;
        end
      end else begin
        if (end_req) m_end_pend = 1;
        if (pkt_ready) begin
          m_items.delete();
          m_sealed = 0;
          if (m_end_pend) begin m_ended = 1; m_end_pend = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("in_ready",       32'(in_ready),       32'(!m_sealed && !m_ended));
      chk("dct_buffer",     32'(dct_buffer),     32'(m_pack()));
      chk("dct_count",      32'(dct_count),      32'(m_items.size()));
      chk("pkt_valid",      32'(pkt_valid),      32'(m_sealed));
      if (m_sealed) begin
        chk("pkt_data",     32'(pkt_data),       32'(m_pack()));
        chk("pkt_count",    32'(pkt_count),      32'(m_items.size()));
      end
      chk("test_ending",    32'(test_ending),    32'(m_end_pend && !m_ended));
      chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
    end
  end

  // Drive one cycle of inputs starting just after an edge; returns 2 ns after
  // the following edge, where registered outputs have settled.
  task automatic cyc(input logic v, input logic [1:0] b, input logic fl,
                     input logic er, input logic pr);
    in_valid = v; in_bits = b; flush = fl; end_req = er; pkt_ready = pr;
    @(posedge clk); #2;
    in_valid = 0; flush = 0; end_req = 0; pkt_ready = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    @(posedge clk); #2;
    reset_n = 1;
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_bits = '0; flush = 0; end_req = 0; pkt_ready = 0;
    #1;
    chk("rst_dct_count", 32'(dct_count), 32'h0);
    chk("rst_pkt_valid", 32'(pkt_valid), 32'h0);
    chk("rst_has_ended", 32'(test_has_ended), 32'h0);
    @(posedge clk); #2;
    reset_n = 1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Scenario 1: fifteen 2'b01 items fill a packet.
    for (int i = 0; i < 15; i++) cyc(1, 2'b01, 0, 0, 0);
    chk("s1_in_ready",  32'(in_ready),  32'h0);
    chk("s1_pkt_valid", 32'(pkt_valid), 32'h1);
    chk("s1_pkt_data",  32'(pkt_data),  32'h15555555);
    chk("s1_pkt_count", 32'(pkt_count), 32'd15);
    cyc(1, 2'b11, 0, 0, 0);
    chk("s1_no_overflow", 32'(dct_count), 32'd15);
    cyc(0, 2'b00, 0, 0, 1);
    chk("s1_cleared", 32'(dct_count), 32'h0);
    chk("s1_refill",  32'(in_ready),  32'h1);

    // Scenario 2: three items then flush.
    cyc(1, 2'b11, 0, 0, 0);
    cyc(1, 2'b00, 0, 0, 0);
    cyc(1, 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 1, 0, 0);
    chk("s2_pkt_data",  32'(pkt_data),  32'h32);
    chk("s2_pkt_count", 32'(pkt_count), 32'd3);
    cyc(0, 2'b00, 1, 0, 0);
    chk("s2_hold_flush", 32'(pkt_data), 32'h32);
    cyc(0, 2'b00, 0, 0, 1);
    chk("s2_dct_count", 32'(dct_count), 32'h0);
    chk("s2_in_ready",  32'(in_ready),  32'h1);

    // Scenario 3: empty flush ignored.
    cyc(0, 2'b00, 1, 0, 0);
    chk("s3_pkt_valid", 32'(pkt_valid), 32'h0);
    chk("s3_in_ready",  32'(in_ready),  32'h1);

    // Item and flush together: the item is part of the packet.
    cyc(1, 2'b01, 1, 0, 0);
    chk("flush_item_count", 32'(pkt_count), 32'd1);
    chk("flush_item_data",  32'(pkt_data),  32'h1);
    cyc(0, 2'b00, 0, 0, 1);

    // Scenario 4: two items, end_req, stalled drain.
    cyc(1, 2'b10, 0, 0, 0);
    cyc(1, 2'b01, 0, 0, 0);
    cyc(0, 2'b00, 0, 1, 0);
    chk("s4_drain_data", 32'(pkt_data), 32'h9);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2'b00, 1, 1, 0);
      chk("s4_ending", 32'(test_ending), 32'h1);
    end
    cyc(0, 2'b00, 0, 0, 1);
    chk("s4_has_ended", 32'(test_has_ended), 32'h1);
    chk("s4_ending_off", 32'(test_ending), 32'h0);
    cyc(1, 2'b11, 1, 1, 1);
    chk("s4_no_accept", 32'(dct_count), 32'h0);
    chk("s4_in_ready",  32'(in_ready),  32'h0);

    // end_req while holding is latched and ends on acceptance.
    do_reset();
    cyc(1, 2'b11, 1, 0, 0);
    cyc(0, 2'b00, 0, 1, 0);
    chk("hold_end_ending", 32'(test_ending), 32'h1);
    cyc(0, 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 1);
    chk("hold_end_ended", 32'(test_has_ended), 32'h1);

    // Scenario 5: asynchronous reset while a packet is pending.
    do_reset();
    cyc(1, 2'b10, 1, 0, 0);
    cyc(0, 2'b00, 0, 0, 0);
    reset_n = 0;
    #1;
    chk("s5_pkt_valid", 32'(pkt_valid),  32'h0);
    chk("s5_buffer",    32'(dct_buffer), 32'h0);
    chk("s5_count",     32'(dct_count),  32'h0);
    chk("s5_ending",    32'(test_ending), 32'h0);
    chk("s5_ended",     32'(test_has_ended), 32'h0);
    @(posedge clk); #2;
    reset_n = 1;
    chk("s5_in_ready", 32'(in_ready), 32'h1);

    // Scenario 6: 15th item together with end_req.
    for (int i = 0; i < 14; i++) cyc(1, 2'b10, 0, 0, 0);
    cyc(1, 2'b11, 0, 1, 0);
    chk("s6_pkt_count", 32'(pkt_count), 32'd15);
    chk("s6_pkt_data",  32'(pkt_data),  32'h2AAAAAAB);
    chk("s6_ending",    32'(test_ending), 32'h1);
    cyc(0, 2'b00, 0, 0, 1);
    chk("s6_has_ended", 32'(test_has_ended), 32'h1);
    chk("s6_pkt_valid", 32'(pkt_valid), 32'h0);

    @(posedge clk); #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
